// File: rtl/frame_stream_arbiter_if.sv
// Multi-lane valid/ready word stream used on both sides of the frame arbiter.
// Lane c carries its word at data[c*W +: W].
interface frame_stream_arbiter_if #(
    parameter int N = 1,
    parameter int W = 64
);
    logic [N*W-1:0] data;
    logic [N-1:0]   valid;
    logic [N-1:0]   ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/frame_stream_arbiter.sv
// Round-robin merge of per-channel framed streams into one readout stream.
// A grant holds until the footer word passes or the length watchdog trips.
module frame_stream_arbiter #(
    parameter int          N_CH             = 4,
    parameter int          CH_ID_WIDTH      = 2,
    parameter int          DOUT_WIDTH       = 64,
    parameter int          MAX_FRAME_LENGTH = 200,
    parameter logic [7:0]  FOOTER_ID        = 8'h55
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [N_CH-1:0]        CH_ENABLE,
    frame_stream_arbiter_if.slave  chIn,
    frame_stream_arbiter_if.master dOut,
    output logic [CH_ID_WIDTH-1:0] GRANT_CH,
    output logic                   BUSY,
    output logic                   FRAME_ERR,
    output logic [CH_ID_WIDTH-1:0] ERR_CH
);

    localparam int CNT_W = $clog2(MAX_FRAME_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FRAME_LENGTH - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        wordCnt;
    logic [DOUT_WIDTH-1:0]   doutQ;
    logic                    oValidQ;

    logic [N_CH-1:0]         req;
    logic [CH_ID_WIDTH-1:0]  nextCh;
    logic                    found;
    int                      idx;
    logic [DOUT_WIDTH-1:0]   wordIn;
    logic                    selValid;
    logic                    slotFree;
    logic                    accept;
    logic                    isFooter;

    assign req = chIn.valid & CH_ENABLE;

    // First requester after the last grant, wrapping around.
    always_comb begin
        nextCh = GRANT_CH;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(GRANT_CH) + i) % N_CH;
            if (!found && |(req & (N_CH'(1) << idx))) begin
                found  = 1'b1;
                nextCh = CH_ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        wordIn = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (GRANT_CH == CH_ID_WIDTH'(c)) begin
                wordIn = chIn.data[c*DOUT_WIDTH +: DOUT_WIDTH];
            end
        end
    end

    assign selValid = |(chIn.valid & (N_CH'(1) << GRANT_CH));
    assign slotFree = !oValidQ || dOut.ready[0];
    assign accept   = (state == LOCK) && slotFree && selValid;
    assign isFooter = (wordIn[DOUT_WIDTH-1 -: 8] == FOOTER_ID);

    always_comb begin
        chIn.ready = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (state == LOCK && slotFree && GRANT_CH == CH_ID_WIDTH'(c)) begin
                chIn.ready[c] = 1'b1;
            end
        end
    end

    assign dOut.data  = doutQ;
    assign dOut.valid = oValidQ;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            GRANT_CH  <= CH_ID_WIDTH'(N_CH - 1);
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
            ERR_CH    <= '0;
            wordCnt   <= '0;
            doutQ     <= '0;
            oValidQ   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;

            if (accept) begin
                doutQ   <= wordIn;
                oValidQ <= 1'b1;
            end else if (dOut.ready[0]) begin
                oValidQ <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (found) begin
                        GRANT_CH <= nextCh;
                        BUSY     <= 1'b1;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        // The word that hits the limit is still forwarded.
                        if (isFooter || wordCnt == LAST_CNT) begin
                            state   <= IDLE;
                            BUSY    <= 1'b0;
                            wordCnt <= '0;
                            if (!isFooter) begin
                                FRAME_ERR <= 1'b1;
                                ERR_CH    <= GRANT_CH;
                            end
                        end else begin
                            wordCnt <= wordCnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
